// File: rtl/gpio_port_if.sv
// CPU data-bus port of gpio_port: one-cycle read/write request pulses in,
// registered one-cycle ready pulses and held read data out; never stalls.
interface gpio_port_if #(
    parameter int SIZE_ADDR = 4
);
    logic                 read;
    logic                 write;
    logic [SIZE_ADDR-1:0] address;
    logic [7:0]           data_in;
    logic [7:0]           data_out;
    logic                 ready_r;
    logic                 ready_w;

    modport master (output read, write, address, data_in,
                    input  data_out, ready_r, ready_w);
    modport slave  (input  read, write, address, data_in,
                    output data_out, ready_r, ready_w);
endinterface

// File: rtl/gpio_port.sv
// Banked memory-mapped GPIO with input synchroniser, edge flags and level irq.
// Request at edge N is applied at edge N, ready pulses in cycle N+1; no backpressure.
module gpio_port #(
    parameter int NUM_BANKS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    gpio_port_if.slave             bus,
    input  logic [8*NUM_BANKS-1:0] pin_in,
    output logic [8*NUM_BANKS-1:0] pin_out,
    output logic [8*NUM_BANKS-1:0] pin_oe,
    output logic                   irq
);
    localparam int SIZE_ADDR = $clog2(NUM_BANKS) + 3;
    localparam int PW        = 8 * NUM_BANKS;

    typedef logic [NUM_BANKS-1:0][7:0] bank_regs_t;

    bank_regs_t                     out_q, out_d;
    bank_regs_t                     dir_q, dir_d;
    bank_regs_t                     en_q, en_d;
    bank_regs_t                     flag_q, flag_d;
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
    logic [PW-1:0]                  prev_q, prev_d;
    logic [7:0]                     data_out_q, data_out_d;
    logic                           ready_r_q, ready_r_d;
    logic                           ready_w_q, ready_w_d;

    logic [SIZE_ADDR-1:0]           addr;
    logic [31:0]                    bank_idx;
    logic [2:0]                     reg_sel;
    logic [PW-1:0]                  in_sync;
    logic [PW-1:0]                  edge_det;

    assign addr     = bus.address;
    assign bank_idx = 32'(addr >> 3);
    assign reg_sel  = addr[2:0];
    assign in_sync  = sync_q[SYNC_STAGES-1];
    // prev_q is all-zero like the sync chain after reset, so no edge fires right out of reset
    assign edge_det = in_sync ^ prev_q;

    always_comb begin
        out_d      = out_q;
        dir_d      = dir_q;
        en_d       = en_q;
        flag_d     = flag_q;
        data_out_d = data_out_q;
        ready_r_d  = bus.read;
        ready_w_d  = bus.write;
        prev_d     = in_sync;
        sync_d     = {sync_q[SYNC_STAGES-2:0], pin_in};

        // Unpopulated banks read as zero; reads always see pre-write state.
        if (bus.read) begin
            data_out_d = 8'h00;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_idx == 32'(b)) begin
                if (bus.read) begin
                    case (reg_sel)
                        3'd0, 3'd1, 3'd2, 3'd3: data_out_d = out_q[b];
                        3'd4:                   data_out_d = dir_q[b];
                        3'd5:                   data_out_d = in_sync[8*b +: 8];
                        3'd6:                   data_out_d = en_q[b];
                        default:                data_out_d = flag_q[b];
                    endcase
                end
                if (bus.write) begin
                    case (reg_sel)
                        3'd0:    out_d[b]  = bus.data_in;
                        3'd1:    out_d[b]  = out_q[b] | bus.data_in;
                        3'd2:    out_d[b]  = out_q[b] & ~bus.data_in;
                        3'd3:    out_d[b]  = out_q[b] ^ bus.data_in;
                        3'd4:    dir_d[b]  = bus.data_in;
                        3'd6:    en_d[b]   = bus.data_in;
                        3'd7:    flag_d[b] = flag_q[b] & ~bus.data_in;
                        default: ;
                    endcase
                end
            end
            // Applied after the write-1-clear so a same-cycle edge wins.
            flag_d[b] = flag_d[b] | (edge_det[8*b +: 8] & en_q[b]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            dir_q      <= '0;
            en_q       <= '0;
            flag_q     <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            data_out_q <= 8'h00;
            ready_r_q  <= 1'b0;
            ready_w_q  <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            en_q       <= en_d;
            flag_q     <= flag_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            data_out_q <= data_out_d;
            ready_r_q  <= ready_r_d;
            ready_w_q  <= ready_w_d;
        end
    end

    assign pin_out      = out_q;
    assign pin_oe       = dir_q;
    assign irq          = |flag_q;
    assign bus.data_out = data_out_q;
    assign bus.ready_r  = ready_r_q;
    assign bus.ready_w  = ready_w_q;
endmodule

// File: tb/tb_gpio_port.sv
// Directed and random bench for gpio_port with a register-level reference model.
module tb_gpio_port;
    localparam int NB = 3;
    localparam int SS = 2;
    localparam int AW = $clog2(NB) + 3;
    localparam int PW = 8 * NB;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] pin_in;
    logic [PW-1:0] pin_out;
    logic [PW-1:0] pin_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    // Reference model: plain register arrays plus a history of sampled pin words.
    logic [7:0]    m_out  [NB];
    logic [7:0]    m_dir  [NB];
    logic [7:0]    m_en   [NB];
    logic [7:0]    m_flag [NB];
    logic [PW-1:0] hist   [$];
    logic [7:0]    m_rdata;
    logic [PW-1:0] pins;

    gpio_port_if #(.SIZE_ADDR(AW)) bus ();

    gpio_port #(.NUM_BANKS(NB), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_out[b]  = 8'h00;
            m_dir[b]  = 8'h00;
            m_en[b]   = 8'h00;
            m_flag[b] = 8'h00;
        end
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back('0);
        m_rdata = 8'h00;
    endtask

    // IN shows the pin word sampled SS edges ago.
    function automatic logic [7:0] model_read(input int b, input int r);
        logic [PW-1:0] in_now;
        if (b >= NB) return 8'h00;
        in_now = hist[SS-1];
        case (r)
            0, 1, 2, 3: return m_out[b];
            4:          return m_dir[b];
            5:          return in_now[8*b +: 8];
            6:          return m_en[b];
            default:    return m_flag[b];
        endcase
    endfunction

    task automatic cycle(input logic rst, input logic rd, input logic wr,
                         input int bank, input int r, input logic [7:0] wd);
        logic [PW-1:0] edges;
        logic [PW-1:0] exp_out;
        logic [PW-1:0] exp_oe;
        logic [7:0]    set_bits [NB];
        logic          any_flag;
        reset        = rst;
        bus.read     = rd;
        bus.write    = wr;
        bus.address  = AW'(bank * 8 + r);
        bus.data_in  = wd;
        pin_in       = pins;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            edges = hist[SS-1] ^ hist[SS];
            for (int b = 0; b < NB; b++) set_bits[b] = edges[8*b +: 8] & m_en[b];
            if (rd) m_rdata = model_read(bank, r);
            if (wr && bank < NB) begin
                case (r)
                    0:       m_out[bank]  = wd;
                    1:       m_out[bank]  = m_out[bank] | wd;
                    2:       m_out[bank]  = m_out[bank] & ~wd;
                    3:       m_out[bank]  = m_out[bank] ^ wd;
                    4:       m_dir[bank]  = wd;
                    6:       m_en[bank]   = wd;
                    7:       m_flag[bank] = m_flag[bank] & ~wd;
                    default: ;
                endcase
            end
            for (int b = 0; b < NB; b++) m_flag[b] = m_flag[b] | set_bits[b];
            hist.push_front(pins);
            void'(hist.pop_back());
        end
        #1;
        any_flag = 1'b0;
        for (int b = 0; b < NB; b++) begin
            exp_out[8*b +: 8] = m_out[b];
            exp_oe[8*b +: 8]  = m_dir[b];
            any_flag          = any_flag | (|m_flag[b]);
        end
        chk("ready_r",  32'(bus.ready_r),  32'(rd & ~rst));
        chk("ready_w",  32'(bus.ready_w),  32'(wr & ~rst));
        chk("data_out", 32'(bus.data_out), 32'(m_rdata));
        chk("pin_out",  32'(pin_out),      32'(exp_out));
        chk("pin_oe",   32'(pin_oe),       32'(exp_oe));
        chk("irq",      32'(irq),          32'(any_flag));
        reset     = 1'b0;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.address = '0;
        bus.data_in = 8'h00;
        pins        = '0;
        pin_in      = '0;
        model_reset();
        cycle(1, 0, 0, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 0, 8'h00);

        // Reset state of every register, including the unpopulated bank 3.
        for (int b = 0; b <= NB; b++) begin
            for (int r = 0; r < 8; r++) begin
                cycle(0, 1, 0, b, r, 8'h00);
                chk("reset_read", 32'(bus.data_out), 32'h00);
            end
        end
        chk("reset_irq", 32'(irq), 32'h0);

        // OUT and its set/clear/toggle aliases.
        cycle(0, 0, 1, 0, 0, 8'hA5); chk("out_write", 32'(pin_out[7:0]), 32'hA5);
        cycle(0, 0, 1, 0, 1, 8'h0A); chk("out_set",   32'(pin_out[7:0]), 32'hAF);
        cycle(0, 0, 1, 0, 2, 8'h81); chk("out_clr",   32'(pin_out[7:0]), 32'h2E);
        cycle(0, 0, 1, 0, 3, 8'hFF); chk("out_tgl",   32'(pin_out[7:0]), 32'hD1);
        cycle(0, 0, 1, 1, 4, 8'h3C); chk("dir_b1",    32'(pin_oe[15:8]), 32'h3C);

        // Rising edge on pin 3 through the synchroniser.
        cycle(0, 0, 1, 0, 6, 8'h08);
        pins[3] = 1'b1;
        for (int i = 0; i < SS; i++) cycle(0, 0, 0, 0, 0, 8'h00);
        cycle(0, 1, 0, 0, 5, 8'h00); chk("in_bit3",   32'(bus.data_out), 32'h08);
        cycle(0, 1, 0, 0, 7, 8'h00); chk("flag_set",  32'(bus.data_out), 32'h08);
        chk("irq_set", 32'(irq), 32'h1);
        cycle(0, 0, 1, 0, 7, 8'h08); chk("irq_clr",   32'(irq), 32'h0);
        cycle(0, 1, 0, 0, 7, 8'h00); chk("flag_clr",  32'(bus.data_out), 32'h00);

        // Falling edge on pin 3 landing on the same edge as a write-1-clear.
        pins[3] = 1'b0;
        cycle(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < SS - 1; i++) cycle(0, 0, 0, 0, 0, 8'h00);
        cycle(0, 0, 1, 0, 7, 8'h08);
        cycle(0, 1, 0, 0, 7, 8'h00); chk("set_wins",  32'(bus.data_out), 32'h08);
        cycle(0, 0, 1, 0, 7, 8'h08);

        // Same-cycle read and write of OUT.
        cycle(0, 0, 1, 0, 0, 8'h12);
        cycle(0, 1, 1, 0, 0, 8'h34);
        chk("rw_old_data", 32'(bus.data_out), 32'h12);
        chk("rw_new_pin",  32'(pin_out[7:0]), 32'h34);

        // Unpopulated bank and a write dropped by reset.
        cycle(0, 0, 1, 3, 0, 8'hFF);
        cycle(0, 1, 0, 3, 0, 8'h00); chk("bank3_read", 32'(bus.data_out), 32'h00);
        cycle(1, 0, 1, 1, 0, 8'hFF); chk("rst_drop_rdy", 32'(bus.ready_w), 32'h0);
        cycle(0, 1, 0, 1, 0, 8'h00); chk("rst_drop_reg", 32'(bus.data_out), 32'h00);

        // Random traffic with wandering pins.
        cycle(0, 0, 1, 0, 6, 8'hFF);
        cycle(0, 0, 1, 1, 6, 8'hF0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) pins = pins ^ PW'($urandom);
            cycle(1'($urandom_range(0, 150) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
